// File: rtl/load_store_unit.sv
// Memory-access stage: D-form EA generation, byte/half/word/doubleword loads and stores
// against a 64-bit word-addressed memory. Define LSU_MISALIGN_TRAP_EN to fault misaligned EAs.
module load_store_unit #(
    parameter int ADDR_BITS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_base,
    input  logic [15:0] req_disp,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic [63:0] mem_read_address,
    input  logic [63:0] mem_read_data,
    output logic        mem_write,
    output logic [63:0] mem_write_address,
    output logic [63:0] mem_write_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [63:0]          wr_data_q, wr_data_d;
    logic [63:0]          rdata_q, rdata_d;
    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_error_q, resp_error_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;

    logic [2:0]           off_q, off_d;
    logic [1:0]           size_q, size_d;
    logic                 sgn_q, sgn_d;
    logic                 store_q, store_d;
    logic                 err_q, err_d;
    logic [63:0]          wdata_q, wdata_d;

    logic [63:0]          ea;
    logic [ADDR_BITS+2:0] ea_lo;
    logic [2:0]           amask;
    logic                 range_fault;
    logic                 misalign;
    logic                 fault;

    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

    // Big-endian lanes: shift the addressed byte to the top, then take the top size bytes.
    function automatic logic [63:0] load_extract(input logic [63:0] word, input logic [2:0] off,
                                                 input logic [1:0] size, input logic sgn);
        logic [63:0] shifted;
        shifted = word << {off, 3'b000};
        case (size)
            2'd0:    load_extract = {{56{sgn & shifted[63]}}, shifted[63:56]};
            2'd1:    load_extract = {{48{sgn & shifted[63]}}, shifted[63:48]};
            2'd2:    load_extract = {{32{sgn & shifted[63]}}, shifted[63:32]};
            default: load_extract = shifted;
        endcase
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] wdata,
                                                input logic [2:0] off, input logic [1:0] size);
        logic [63:0] lane_mask;
        logic [63:0] lane_data;
        case (size)
            2'd0: begin
                lane_mask = {8'hFF, 56'd0};
                lane_data = {wdata[7:0], 56'd0};
            end
            2'd1: begin
                lane_mask = {16'hFFFF, 48'd0};
                lane_data = {wdata[15:0], 48'd0};
            end
            2'd2: begin
                lane_mask = {32'hFFFF_FFFF, 32'd0};
                lane_data = {wdata[31:0], 32'd0};
            end
            default: begin
                lane_mask = '1;
                lane_data = wdata;
            end
        endcase
        lane_mask   = lane_mask >> {off, 3'b000};
        lane_data   = lane_data >> {off, 3'b000};
        store_merge = (old & ~lane_mask) | lane_data;
    endfunction

    always_comb begin
        ea          = req_base + {{48{req_disp[15]}}, req_disp};
        amask       = align_mask(req_size);
        range_fault = |(ea >> (ADDR_BITS + 3));
`ifdef LSU_MISALIGN_TRAP_EN
        ea_lo       = ea[ADDR_BITS+2:0];
        misalign    = |(ea[2:0] & amask);
`else
        ea_lo       = {ea[ADDR_BITS+2:3], ea[2:0] & ~amask};
        misalign    = 1'b0;
`endif
        fault       = range_fault | misalign;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_data_d = wr_data_q;
        rdata_d   = rdata_q;
        off_d     = off_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        store_d   = store_q;
        err_d     = err_q;
        wdata_d   = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d   = ea_lo[ADDR_BITS+2:3];
                    off_d   = ea_lo[2:0];
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    store_d = req_store;
                    wdata_d = req_wdata;
                    err_d   = fault;
                    rdata_d = '0;
                    if (fault) begin
                        state_d = RESP;
                    end else if (req_store && req_size == 2'b11) begin
                        // Full doubleword store needs no read-back.
                        wr_data_d = req_wdata;
                        state_d   = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (store_q) begin
                    wr_data_d = store_merge(mem_read_data, wdata_q, off_q, size_q);
                    state_d   = WRITE;
                end else begin
                    rdata_d = load_extract(mem_read_data, off_q, size_q, sgn_q);
                    state_d = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        resp_error_d = (state_d == RESP) & err_d;
        mem_read_d   = (state_d == READ);
        mem_write_d  = (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wr_data_q    <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_data_q    <= wr_data_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    // Captured request fields only matter after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        off_q   <= off_d;
        size_q  <= size_d;
        sgn_q   <= sgn_d;
        store_q <= store_d;
        err_q   <= err_d;
        wdata_q <= wdata_d;
    end

    assign req_ready         = req_ready_q;
    assign resp_valid        = resp_valid_q;
    assign resp_rdata        = rdata_q;
    assign resp_error        = resp_error_q;
    assign mem_read          = mem_read_q;
    assign mem_write         = mem_write_q;
    assign mem_read_address  = {{(64-ADDR_BITS){1'b0}}, idx_q};
    assign mem_write_address = {{(64-ADDR_BITS){1'b0}}, idx_q};
    assign mem_write_data    = wr_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory model, random and directed requests,
// per-cycle output checking against the model.
`timescale 1ns/1ps
module tb_load_store_unit;
    localparam int AB = 7;
    localparam int NW = 1 << AB;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic [63:0] LWZ0A_ERR = 64'd1;
    localparam logic [63:0] LWZ0A_LAT = 64'd1;
`else
    localparam logic [63:0] LWZ0A_ERR = 64'd0;
    localparam logic [63:0] LWZ0A_LAT = 64'd2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store, req_signed;
    logic [1:0]  req_size;
    logic [63:0] req_base, req_wdata;
    logic [15:0] req_disp;
    logic        resp_valid, resp_ready, resp_error;
    logic [63:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_read_address, mem_read_data, mem_write_address, mem_write_data;

    load_store_unit #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_base(req_base),
        .req_disp(req_disp), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_error(resp_error),
        .mem_read(mem_read), .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
        .mem_write(mem_write), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT, with a backdoor port for preloading.
    logic [63:0]   mem [NW];
    logic          bd_we = 1'b0;
    logic [AB-1:0] bd_idx = '0;
    logic [63:0]   bd_val = '0;
    assign mem_read_data = mem[mem_read_address[AB-1:0]];
    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        else if (mem_write) mem[mem_write_address[AB-1:0]] <= mem_write_data;
    end

    typedef struct {
        logic          err;
        logic [63:0]   rdata;
        int            lat;
        int            nrd;
        int            nwr;
        logic [AB-1:0] widx;
        logic [63:0]   wword;
    } exp_t;

    logic [63:0] mm [NW];
    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [63:0] w, input int b);
        byte_of = 8'((w >> (8 * (7 - b))) & 64'hFF);
    endfunction

    task automatic model_req(input logic st, input logic [1:0] sz, input logic sg,
                             input logic [63:0] base, input logic [15:0] disp,
                             input logic [63:0] wd);
        exp_t        e;
        logic [63:0] ea, w, v, nb;
        int          n, off, wi, sh;
        n  = 1 << sz;
        nb = 64'(n);
        ea = base + {{48{disp[15]}}, disp};
        e.err = 1'b0; e.rdata = '0; e.lat = 1; e.nrd = 0; e.nwr = 0; e.widx = '0; e.wword = '0;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((ea % nb) != 0) e.err = 1'b1;
`else
        ea = ea - (ea % nb);
`endif
        if (ea >= 64'(NW * 8)) e.err = 1'b1;
        if (!e.err) begin
            wi     = int'(ea >> 3);
            off    = int'(ea & 64'd7);
            e.widx = wi[AB-1:0];
            w      = mm[wi];
            if (!st) begin
                v = '0;
                for (int k = 0; k < n; k++) v = (v << 8) | 64'(byte_of(w, off + k));
                if (sg && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                e.rdata = v; e.lat = 2; e.nrd = 1;
            end else begin
                for (int k = 0; k < n; k++) begin
                    sh = 8 * (7 - (off + k));
                    w  = (w & ~(64'hFF << sh)) | (((wd >> (8 * (n - 1 - k))) & 64'hFF) << sh);
                end
                mm[wi]  = w;
                e.wword = w;
                e.nwr   = 1;
                e.nrd   = (n == 8) ? 0 : 1;
                e.lat   = (n == 8) ? 2 : 3;
            end
        end
        exp_q.push_back(e);
    endtask

    // Compare process: checks every cycle against the expectation popped at accept.
    exp_t        cur;
    bit          busy = 1'b0;
    int          c = 0, nrd = 0, nwr = 0, rcyc = 0;
    int          last_lat = 0, last_wr_c = 0, last_nrd = 0, last_nwr = 0, last_rcyc = 0;
    logic [63:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            chk("reset_state",
                64'({req_ready, resp_valid, resp_error, mem_read, mem_write, |resp_rdata,
                     |mem_read_address, |mem_write_address, |mem_write_data}),
                64'(9'b1_0000_0000));
        end else if (!busy) begin
            chk("idle_outputs", 64'({req_ready, resp_valid, mem_read, mem_write}), 64'(4'b1000));
            if (req_valid) begin
                if (exp_q.size() == 0) begin
                    chk("exp_queue_nonempty", 64'd0, 64'd1);
                end else begin
                    cur = exp_q.pop_front();
                    busy = 1'b1; c = 0; nrd = 0; nwr = 0; rcyc = 0;
                end
            end
        end else begin
            c++;
            chk("req_ready_busy", 64'(req_ready), 64'd0);
            if (mem_read) begin
                nrd++;
                chk("rd_addr", mem_read_address, 64'(cur.widx));
            end
            if (mem_write) begin
                nwr++;
                last_wr_c = c;
                chk("wr_addr", mem_write_address, 64'(cur.widx));
                chk("wr_data", mem_write_data, cur.wword);
            end
            if (resp_valid) begin
                if (rcyc == 0) begin
                    chk("latency", 64'(c), 64'(cur.lat));
                    last_lat = c;
                end
                rcyc++;
                chk("resp_rdata", resp_rdata, cur.rdata);
                chk("resp_error", 64'(resp_error), 64'(cur.err));
                if (resp_ready) begin
                    chk("n_reads", 64'(nrd), 64'(cur.nrd));
                    chk("n_writes", 64'(nwr), 64'(cur.nwr));
                    last_rdata = resp_rdata; last_err = resp_error;
                    last_nrd = nrd; last_nwr = nwr; last_rcyc = rcyc;
                    busy = 1'b0;
                end
            end else if (rcyc != 0) begin
                chk("resp_valid_held", 64'(resp_valid), 64'd1);
            end
            if (busy && c > 40) begin
                chk("resp_timeout", 64'(c), 64'(cur.lat));
                busy = 1'b0;
            end
        end
    end

    // Writeback side: optional backpressure before each handshake.
    int bp_force = -1;
    int bp_left = 0;
    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (resp_ready) resp_ready = 1'b0;
            else if (resp_valid) begin
                if (bp_left == 0) resp_ready = 1'b1;
                else bp_left--;
            end else begin
                bp_left = (bp_force >= 0) ? bp_force : int'($urandom_range(0, 3));
            end
        end
    end

    task automatic poke(input int idx, input logic [63:0] val);
        mm[idx] = val;
        bd_we = 1'b1; bd_idx = idx[AB-1:0]; bd_val = val;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [63:0] base, input logic [15:0] disp, input logic [63:0] wd);
        logic r;
        int   g;
        model_req(st, sz, sg, base, disp, wd);
        req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
        req_base = base; req_disp = disp; req_wdata = wd;
        g = 0;
        do begin
            r = req_ready;
            @(posedge clk); #1;
            g++;
        end while (!r && g < 60);
        if (!r) chk("accept_timeout", 64'(g), 64'd0);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || exp_q.size() != 0) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 200) chk("idle_timeout", 64'(g), 64'd0);
    endtask

    logic [63:0] saved;
    logic [63:0] rb, rw;
    logic [15:0] rd;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_base = '0; req_disp = '0; req_wdata = '0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NW; i++) poke(i, {$urandom, $urandom});
        rst_n = 1'b1;
        @(posedge clk); #1;

        poke(1, 64'h1122334455667788);
        issue(1'b1, 2'd0, 1'b0, 64'h8, 16'd3, 64'hAB);
        wait_idle();
        chk("stb_word1", mem[1], 64'h112233AB55667788);
        chk("stb_write_cycle", 64'(last_wr_c), 64'd2);
        chk("stb_latency", 64'(last_lat), 64'd3);
        chk("stb_rdata", last_rdata, 64'd0);

        poke(2, 64'hFFFFFFFFFFFFFF80);
        issue(1'b0, 2'd0, 1'b1, 64'h17, 16'd0, 64'd0);
        wait_idle();
        chk("lbz_signed", last_rdata, 64'hFFFFFFFFFFFFFF80);
        chk("lbz_latency", 64'(last_lat), 64'd2);
        issue(1'b0, 2'd0, 1'b0, 64'h17, 16'd0, 64'd0);
        wait_idle();
        chk("lbz_unsigned", last_rdata, 64'h0000000000000080);

        issue(1'b1, 2'd3, 1'b0, 64'h20, 16'hFFF8, 64'hDEADBEEF00000001);
        wait_idle();
        chk("std_word3", mem[3], 64'hDEADBEEF00000001);
        chk("std_no_read", 64'(last_nrd), 64'd0);
        chk("std_one_write", 64'(last_nwr), 64'd1);
        issue(1'b0, 2'd3, 1'b0, 64'h18, 16'd0, 64'd0);
        wait_idle();
        chk("ld_after_std", last_rdata, 64'hDEADBEEF00000001);

        issue(1'b0, 2'd2, 1'b0, 64'h0A, 16'd0, 64'd0);
        wait_idle();
        chk("lwz_0a_error", 64'(last_err), LWZ0A_ERR);
        chk("lwz_0a_latency", 64'(last_lat), LWZ0A_LAT);
        issue(1'b0, 2'd3, 1'b0, 64'h400, 16'd0, 64'd0);
        wait_idle();
        chk("ld_400_error", 64'(last_err), 64'd1);
        chk("ld_400_latency", 64'(last_lat), 64'd1);

        bp_force = 3;
        issue(1'b0, 2'd3, 1'b0, 64'h18, 16'd0, 64'd0);
        issue(1'b0, 2'd1, 1'b1, 64'h16, 16'd0, 64'd0);
        wait_idle();
        chk("bp_resp_cycles", 64'(last_rcyc), 64'd4);
        chk("bp_second_rdata", last_rdata, 64'hFFFFFFFFFFFFFF80);
        bp_force = -1;

        saved = mm[2];
        issue(1'b1, 2'd1, 1'b0, 64'h10, 16'd0, 64'h5555);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mm[2] = saved;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_rmw_word2", mem[2], 64'hFFFFFFFFFFFFFF80);

        for (int t = 0; t < 300; t++) begin
            rb = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1100));
            rd = 16'($urandom_range(0, 255)) - 16'd128;
            rw = {$urandom, $urandom};
            issue(1'($urandom), 2'($urandom), 1'($urandom), rb, rd, rw);
        end
        wait_idle();
        for (int i = 0; i < NW; i++) chk("final_mem_word", mem[i], mm[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the uPOWER datapath. Sits between execute and the 64-bit word-addressed data memory. Computes D-form effective addresses and performs byte/half/word/doubleword loads and stores on that memory, using read-modify-write for sub-doubleword stores. Returns load data, sign- or zero-extended, to writeback through a valid/ready handshake.

## Interface
Parameters:
- ADDR_BITS, 7, word-index width; memory holds 2^ADDR_BITS doublewords.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword
- req_signed  in  1  sign-extend load result (ignored for stores and doublewords)
- req_base  in  64  base register value
- req_disp  in  16  displacement, sign-extended to 64
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  writeback accepts response
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_error  out  1  alignment or range fault
- mem_read  out  1  memory read enable
- mem_read_address  out  64  zero-extended word index
- mem_read_data  in  64  combinational memory read data
- mem_write  out  1  memory write enable
- mem_write_address  out  64  zero-extended word index
- mem_write_data  out  64  full doubleword to write

## Operation
- EA = req_base + sext(req_disp), modulo 2^64. EA is captured with all request fields on the accept edge.
- Word index = EA[ADDR_BITS+2:3]. Byte offset = EA[2:0].
- Byte lanes are big-endian: offset 0 maps to bits 63:56.
- Range fault: any EA bit above ADDR_BITS+2 is set.
- Alignment fault (with the macro): EA not a multiple of the access size.
- A faulting request never asserts mem_read or mem_write.
- FSM states and transitions:
  - IDLE: req_ready=1. On accept, go to RESP if faulted, else WRITE if doubleword store, else READ.
  - READ: mem_read=1. Capture mem_read_data into an internal doubleword register. Go to RESP if load, else WRITE.
  - WRITE: mem_write=1. mem_write_data = captured word with the selected lanes replaced by the low bytes of req_wdata; for a doubleword store, req_wdata verbatim. Go to RESP.
  - RESP: resp_valid=1. On resp_ready, go to IDLE.
- Load result: selected lanes right-justified, then sign-extended if req_signed else zero-extended.
- Outputs are stable throughout RESP. req_ready=0 in every state except IDLE.
- mem_read_address and mem_write_address both carry the captured index in every state. Enables are 0 outside READ and WRITE respectively.

## Timing
Latencies are measured from the accept edge to the first resp_valid cycle:
- Faulting request: 1 cycle.
- Load: 2 cycles.
- Doubleword store: 2 cycles.
- Sub-doubleword store: 3 cycles.

Other rules:
- Back-to-back throughput: a new request is accepted no earlier than the cycle after the resp handshake. There is no same-cycle turnaround.
- Reset values: req_ready=1 (IDLE); resp_valid, resp_error, mem_read, mem_write = 0; resp_rdata, all address and data outputs = 0.
- Reset mid-operation returns to IDLE immediately. If rst_n falls before the WRITE-state clock edge, memory is unchanged and no response is issued.
- resp_ready held low keeps the unit in RESP indefinitely with no memory activity.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned accesses raise resp_error.
- LSU_MISALIGN_TRAP_EN undefined: the low log2(size) EA bits are forced to 0 (access silently aligned down) and no alignment fault exists. Range faults apply in both builds.

## Test plan
- Sub-doubleword store: word 1 = 0x1122334455667788; stb base=0x8, disp=3, wdata=0xAB.
  - mem_write asserted 2 cycles after accept.
  - Word 1 becomes 0x112233AB55667788.
  - resp_valid 3 cycles after accept, resp_rdata=0.
- Signed vs unsigned byte load: word 2 = 0xFFFFFFFFFFFFFF80; lbz at EA 0x17.
  - req_signed=1 returns 0xFFFFFFFFFFFFFF80.
  - req_signed=0 returns 0x0000000000000080.
  - Latency 2 cycles.
- Doubleword store: std EA 0x18, wdata 0xDEADBEEF00000001.
  - No mem_read cycle; single mem_write with that exact data.
  - Subsequent ld at EA 0x18 returns it.
- Faults: lwz at EA 0x0A (macro defined) and ld at EA 0x400.
  - Each returns resp_error=1 one cycle after accept.
  - mem_read and mem_write never asserted.
- Backpressure: resp_ready low for 3 cycles after resp_valid.
  - resp_valid, resp_rdata and resp_error held constant.
  - req_ready stays 0; request accepted only after handshake.
- Reset during RMW: rst_n low for the READ cycle of an sth to EA 0x10.
  - Word 2 unchanged, no response.
  - req_ready=1 on the first cycle after release.
